// File: rtl/safe_softmax_exp2_pipe.sv
// safe_softmax_exp2_pipe: 3-stage multi-lane 2^(-x) evaluator (fraction table lookup, integer part as right shift).
// Define SAFE_SOFTMAX_EXP2_INTERP_EN to add round-half-up linear interpolation between table entries.
module safe_softmax_exp2_pipe #(
    parameter int D_W    = 16,
    parameter int INT_W  = 4,
    parameter int FRAC_W = D_W - 3,
    parameter int LANES  = 4
) (
    input  logic                             I_CLK,
    input  logic                             I_RST_N,
    input  logic                             I_VALID,
    output logic                             O_READY,
    input  logic [LANES*(INT_W+FRAC_W)-1:0]  I_X,
    input  logic                             I_LAST,
    output logic                             O_VALID,
    input  logic                             I_READY,
    output logic [LANES*D_W-1:0]             O_Y,
    output logic                             O_LAST
);
    localparam int X_W = INT_W + FRAC_W;
    localparam int R   = FRAC_W - 5;
    localparam int SH  = 16 - D_W;
    localparam logic [16:0] RND = (17'd1 << SH) >> 1;
    localparam logic [15:0] T16 [33] = '{
        16'd8192, 16'd8016, 16'd7845, 16'd7677, 16'd7512, 16'd7351, 16'd7194, 16'd7039,
        16'd6889, 16'd6741, 16'd6597, 16'd6455, 16'd6317, 16'd6182, 16'd6049, 16'd5919,
        16'd5793, 16'd5668, 16'd5547, 16'd5428, 16'd5312, 16'd5198, 16'd5087, 16'd4978,
        16'd4871, 16'd4767, 16'd4664, 16'd4565, 16'd4467, 16'd4371, 16'd4277, 16'd4186,
        16'd4096
    };

    // Narrower outputs reuse the 16-bit table, rounded half-up.
    function automatic logic [D_W-1:0] tbl(input logic [5:0] i);
        return D_W'((17'(T16[i]) + RND) >> SH);
    endfunction

    logic                          w_adv;
    logic                          r_v1, r_l1, r_v2, r_l2;
    logic [LANES-1:0][INT_W-1:0]   r_n1, r_n2;
    logic [LANES-1:0][4:0]         r_idx1;
    logic [LANES-1:0][D_W-1:0]     r_base2, w_m, w_y;

    assign w_adv   = ~O_VALID | I_READY;
    assign O_READY = w_adv;

`ifdef SAFE_SOFTMAX_EXP2_INTERP_EN
    localparam int DL_W = D_W - 6;
    localparam int P_W  = DL_W + R;
    localparam int RNDR = 1 << (R - 1);
    logic [LANES-1:0][R-1:0]       r_r1, r_r2;
    logic [LANES-1:0][D_W-1:0]     r_next2;
    logic [LANES-1:0][DL_W-1:0]    w_delta;
    logic [LANES-1:0][P_W-1:0]     w_prod;
    always_comb begin
        w_delta = '0;
        w_prod  = '0;
        w_m     = '0;
        w_y     = '0;
        for (int k = 0; k < LANES; k++) begin
            w_delta[k] = DL_W'(r_base2[k] - r_next2[k]);
            w_prod[k]  = P_W'(w_delta[k]) * P_W'(r_r2[k]);
            w_m[k]     = r_base2[k] - D_W'((w_prod[k] + P_W'(RNDR)) >> R);
            w_y[k]     = (32'(r_n2[k]) >= D_W - 2) ? '0 : w_m[k] >> r_n2[k];
        end
    end
`else
    logic w_unused_r;
    assign w_unused_r = ^I_X;
    always_comb begin
        w_m = '0;
        w_y = '0;
        for (int k = 0; k < LANES; k++) begin
            w_m[k] = r_base2[k];
            w_y[k] = (32'(r_n2[k]) >= D_W - 2) ? '0 : w_m[k] >> r_n2[k];
        end
    end
`endif

    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            r_v1    <= 1'b0;
            r_l1    <= 1'b0;
            r_v2    <= 1'b0;
            r_l2    <= 1'b0;
            r_n1    <= '0;
            r_n2    <= '0;
            r_idx1  <= '0;
            r_base2 <= '0;
`ifdef SAFE_SOFTMAX_EXP2_INTERP_EN
            r_r1    <= '0;
            r_r2    <= '0;
            r_next2 <= '0;
`endif
            O_VALID <= 1'b0;
            O_LAST  <= 1'b0;
            O_Y     <= '0;
        end else if (w_adv) begin
            r_v1    <= I_VALID;
            r_l1    <= I_LAST;
            r_v2    <= r_v1;
            r_l2    <= r_l1;
            O_VALID <= r_v2;
            O_LAST  <= r_l2;
            for (int k = 0; k < LANES; k++) begin
                r_n1[k]            <= I_X[k*X_W+FRAC_W +: INT_W];
                r_idx1[k]          <= I_X[k*X_W+FRAC_W-5 +: 5];
                r_n2[k]            <= r_n1[k];
                r_base2[k]         <= tbl({1'b0, r_idx1[k]});
`ifdef SAFE_SOFTMAX_EXP2_INTERP_EN
                r_r1[k]            <= I_X[k*X_W +: R];
                r_r2[k]            <= r_r1[k];
                r_next2[k]         <= tbl({1'b0, r_idx1[k]} + 6'd1);
`endif
                O_Y[k*D_W +: D_W]  <= w_y[k];
            end
        end
    end
endmodule

// File: tb/tb_safe_softmax_exp2_pipe.sv
// tb_safe_softmax_exp2_pipe: random and directed stimulus against a scoreboard of arithmetic 2^(-x) values.
module tb_safe_softmax_exp2_pipe;
    localparam int LANES = 4;
    localparam int XW    = 17;

    logic                   clk = 1'b0;
    logic                   I_RST_N = 1'b0;
    logic                   I_VALID = 1'b0;
    logic                   I_LAST = 1'b0;
    logic                   I_READY = 1'b0;
    logic [LANES*XW-1:0]    I_X = '0;
    logic                   O_READY, O_VALID, O_LAST;
    logic [LANES*16-1:0]    O_Y;

    int total = 0;
    int bad   = 0;
    int outs  = 0;
    logic [64:0] q[$];

    int T[33] = '{8192, 8016, 7845, 7677, 7512, 7351, 7194, 7039, 6889, 6741, 6597,
                  6455, 6317, 6182, 6049, 5919, 5793, 5668, 5547, 5428, 5312, 5198,
                  5087, 4978, 4871, 4767, 4664, 4565, 4467, 4371, 4277, 4186, 4096};

    safe_softmax_exp2_pipe dut (
        .I_CLK(clk), .I_RST_N(I_RST_N), .I_VALID(I_VALID), .O_READY(O_READY),
        .I_X(I_X), .I_LAST(I_LAST), .O_VALID(O_VALID), .I_READY(I_READY),
        .O_Y(O_Y), .O_LAST(O_LAST)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] e2(input int unsigned xl);
        int unsigned n, f, i, r, m;
        n = xl >> 13;
        f = xl & 32'h1FFF;
        i = f >> 8;
        r = f & 32'hFF;
        m = T[i];
`ifdef SAFE_SOFTMAX_EXP2_INTERP_EN
        m = T[i] - ((T[i] - T[i+1]) * r + 128) / 256;
`endif
        return (n >= 14) ? 16'd0 : 16'(m >> n);
    endfunction

    function automatic logic [63:0] model(input logic [LANES*XW-1:0] x);
        logic [63:0] y;
        for (int k = 0; k < LANES; k++) y[k*16 +: 16] = e2(32'(x[k*XW +: XW]));
        return y;
    endfunction

    function automatic logic [LANES*XW-1:0] mk(input int a, input int b, input int c, input int d);
        return {17'(d), 17'(c), 17'(b), 17'(a)};
    endfunction

    function automatic logic [LANES*XW-1:0] rx();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[LANES*XW-1:0];
    endfunction

    task automatic cyc(input logic v, input logic [LANES*XW-1:0] x, input logic l,
                       input logic rd, output logic acc);
        @(negedge clk);
        I_VALID = v;
        I_X     = x;
        I_LAST  = l;
        I_READY = rd;
        #1;
        acc = I_VALID & O_READY;
        if (O_VALID) begin
            if (q.size() == 0) chk("spurious_out", O_VALID, 1'b0);
            else begin
                chk("y_last", {O_LAST, O_Y}, q[0]);
                if (I_READY) begin
                    void'(q.pop_front());
                    outs++;
                end
            end
        end
        if (acc) q.push_back({l, model(x)});
    endtask

    task automatic do_reset();
        @(negedge clk);
        I_RST_N = 1'b0;
        I_VALID = 1'b0;
        I_READY = 1'b0;
        q.delete();
        @(negedge clk);
        I_RST_N = 1'b1;
        #1;
        chk("rst_ovalid", O_VALID, 1'b0);
        chk("rst_oready", O_READY, 1'b1);
        chk("rst_oy", O_Y, '0);
        chk("rst_olast", O_LAST, 1'b0);
    endtask

    initial begin
        logic acc;
        int lat, n, tries, cycles, base;
        logic [LANES*XW-1:0] dx[4];
        do_reset();

        // first beat latency and known values
        cyc(1'b1, mk('h0000, 'h1000, 'h2000, 'h3000), 1'b1, 1'b1, acc);
        lat = 0;
        do begin
            cyc(1'b0, '0, 1'b0, 1'b1, acc);
            lat++;
        end while (!O_VALID && lat < 8);
        chk("latency", 65'(lat), 65'd3);
        chk("basic_vals", {O_LAST, O_Y}, {1'b1, 16'd2896, 16'd4096, 16'd5793, 16'd8192});

        dx[0] = mk('h0080, 'h1FFF, 13 << 13, 14 << 13);
        dx[1] = mk(15 << 13, 'h1FFF | (15 << 13), 'h0001, 'h0100);
        dx[2] = mk(1 << 13 | 'h0080, 12 << 13 | 'h1F00, 'h00FF, 'h1E80);
        dx[3] = mk('h1FFFF, 13 << 13 | 'h1FFF, 'h10FF, 3 << 13 | 'h0880);
        for (int i = 0; i < 4; i++) cyc(1'b1, dx[i], i[0], 1'b1, acc);
        repeat (6) cyc(1'b0, '0, 1'b0, 1'b1, acc);
        chk("directed_drain", 65'(q.size()), 65'd0);

        // backpressure with incrementing x
        n = 0;
        tries = 0;
        while (n < 10 && tries < 300) begin
            cyc(1'b1, mk(n * 'h0321, n * 'h0321 + 'h2000, n * 'h1457, n * 'h2A00), n == 9,
                1'($urandom_range(0, 1)), acc);
            if (acc) n++;
            tries++;
        end
        chk("bp_sent", 65'(n), 65'd10);
        while (q.size() > 0 && tries < 600) begin
            cyc(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), acc);
            tries++;
        end
        chk("bp_drain", 65'(q.size()), 65'd0);

        // random traffic
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), rx(), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) != 0), acc);
        tries = 0;
        while (q.size() > 0 && tries < 50) begin
            cyc(1'b0, '0, 1'b0, 1'b1, acc);
            tries++;
        end
        chk("rand_drain", 65'(q.size()), 65'd0);

        // reset with three beats in flight
        for (int i = 0; i < 3; i++) cyc(1'b1, rx(), 1'b1, 1'b1, acc);
        do_reset();
        repeat (8) cyc(1'b0, '0, 1'b0, 1'b1, acc);
        chk("post_rst_idle", 65'(O_VALID), 65'd0);

        // full throughput
        base = outs;
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, rx(), 1'(i == 99), 1'b1, acc);
            cycles++;
        end
        while (outs - base < 100 && cycles < 130) begin
            cyc(1'b0, '0, 1'b0, 1'b1, acc);
            cycles++;
        end
        chk("thru_count", 65'(outs - base), 65'd100);
        chk("thru_cycles", 65'(cycles), 65'd103);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
